interval_counter_bank: RTL and testbench

- Multi-channel interval counter bank, parametrised in channel count and widths.
- Each channel has a prescaler that counts 0..interval and advances the channel counter once per interval+1 cycles.
- Adds per-channel enable, three counting modes (free-run, auto-reload, one-shot), tick pulses, one-shot done flags and sticky interrupts.
- Sits on the peripheral side as the timebase/event source for software timers and interrupt generation.

---
 rtl/counter_pkg.sv | 19 +
 rtl/counter_channel.sv | 128 ++++++++++++
 rtl/interval_counter_bank.sv | 62 ++++++
 tb/tb_interval_counter_bank.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : counter_pkg                                                |
// | Purpose : Shared constants for the interval counter bank: global     |
// |           command encodings and per-channel counting modes.          |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package counter_pkg;
   // Global command encodings; any other value acts as RESET.
   localparam logic [7:0] STATE_RESET = 8'd0;
   localparam logic [7:0] STATE_RUN   = 8'd1;
   localparam logic [7:0] STATE_HALT  = 8'd2;

   // Per-channel counting modes; 2'b11 behaves as free-run.
   localparam logic [1:0] MODE_FREE    = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;
endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : counter_channel                                            |
// | Purpose : One channel of the interval counter bank: prescaler,       |
// |           counter, tick pulse, one-shot done flag and sticky irq.    |
// | Ports   : clk, resetn (async active-low)                             |
// |           run      - global RUN command decoded by the parent        |
// |           clr      - synchronous clear (RESET or illegal command)    |
// |           en       - channel enable                                  |
// |           mode     - counting mode                                   |
// |           interval - prescale interval (advance every interval+1)    |
// |           limit    - terminal value (reload / one-shot)              |
// |           irq_clr  - interrupt clear pulse                           |
// |           counter, tick, done, irq - registered outputs              |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module counter_channel
   import counter_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               run,
   input  logic               clr,
   input  logic               en,
   input  logic [1:0]         mode,
   input  logic [PRESC_W-1:0] interval,
   input  logic [CNT_W-1:0]   limit,
   input  logic               irq_clr,
   output logic [CNT_W-1:0]   counter,
   output logic               tick,
   output logic               done,
   output logic               irq
);

   logic [PRESC_W-1:0] times_q,   times_d;
   logic [CNT_W-1:0]   counter_q, counter_d;
   logic               tick_q,    tick_d;
   logic               done_q,    done_d;
   logic               irq_q,     irq_d;

   logic               adv;
   logic               irq_set;
   logic [CNT_W-1:0]   cnt_inc;

   always_comb begin
      times_d   = times_q;
      counter_d = counter_q;
      tick_d    = 1'b0;
      done_d    = done_q;
      irq_d     = irq_q;
      adv       = 1'b0;
      irq_set   = 1'b0;
      cnt_inc   = counter_q + CNT_W'(1);

      if (clr) begin
         times_d   = '0;
         counter_d = '0;
         done_d    = 1'b0;
         irq_d     = 1'b0;
      end else begin
         // A finished one-shot freezes the channel regardless of mode.
         if (run && en && !done_q) begin
            adv = (times_q == interval);
            // Covers both normal wrap and an interval lowered below times.
            times_d = (times_q < interval) ? times_q + PRESC_W'(1) : '0;
            if (adv) begin
               tick_d = 1'b1;
               case (mode)
                  MODE_RELOAD: begin
                     if (counter_q >= limit) begin
                        counter_d = '0;
                        irq_set   = 1'b1;
                     end else begin
                        counter_d = cnt_inc;
                     end
                  end
                  MODE_ONESHOT: begin
                     if (counter_q < limit) begin
                        counter_d = cnt_inc;
                        if (cnt_inc == limit) begin
                           done_d  = 1'b1;
                           irq_set = 1'b1;
                        end
                     end else begin
                        // limit==0 (or lowered below counter): finish now.
                        done_d  = 1'b1;
                        irq_set = 1'b1;
                     end
                  end
                  default: begin
                     counter_d = cnt_inc;
                     if (&counter_q) irq_set = 1'b1;
                  end
               endcase
            end
         end
         // Set has priority over a simultaneous clear.
         if (irq_set)      irq_d = 1'b1;
         else if (irq_clr) irq_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         times_q   <= '0;
         counter_q <= '0;
         tick_q    <= 1'b0;
         done_q    <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         times_q   <= times_d;
         counter_q <= counter_d;
         tick_q    <= tick_d;
         done_q    <= done_d;
         irq_q     <= irq_d;
      end
   end

   assign counter = counter_q;
   assign tick    = tick_q;
   assign done    = done_q;
   assign irq     = irq_q;

endmodule : counter_channel
`default_nettype wire

// File: rtl/interval_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : interval_counter_bank                                      |
// | Purpose : Multi-channel interval counter bank. Decodes the global    |
// |           command, slices the flattened per-channel buses and        |
// |           instantiates one counter_channel per channel.              |
// | Ports   : clk, resetn (async active-low), state (global command),    |
// |           ch_en, mode[2*NUM_CH], interval[NUM_CH*PRESC_W],           |
// |           limit[NUM_CH*CNT_W], irq_clr -> counter, tick, done, irq   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module interval_counter_bank
   import counter_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 32
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [7:0]                state,
   input  logic [NUM_CH-1:0]         ch_en,
   input  logic [2*NUM_CH-1:0]       mode,
   input  logic [NUM_CH*PRESC_W-1:0] interval,
   input  logic [NUM_CH*CNT_W-1:0]   limit,
   input  logic [NUM_CH-1:0]         irq_clr,
   output logic [NUM_CH*CNT_W-1:0]   counter,
   output logic [NUM_CH-1:0]         tick,
   output logic [NUM_CH-1:0]         done,
   output logic [NUM_CH-1:0]         irq
);

   logic run;
   logic clr;

   // Anything other than RUN or HALT clears, including undefined codes.
   assign run = (state == STATE_RUN);
   assign clr = !((state == STATE_RUN) || (state == STATE_HALT));

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      counter_channel #(
         .CNT_W   (CNT_W),
         .PRESC_W (PRESC_W)
      ) u_channel (
         .clk      (clk),
         .resetn   (resetn),
         .run      (run),
         .clr      (clr),
         .en       (ch_en[i]),
         .mode     (mode[2*i +: 2]),
         .interval (interval[i*PRESC_W +: PRESC_W]),
         .limit    (limit[i*CNT_W +: CNT_W]),
         .irq_clr  (irq_clr[i]),
         .counter  (counter[i*CNT_W +: CNT_W]),
         .tick     (tick[i]),
         .done     (done[i]),
         .irq      (irq[i])
      );
   end

endmodule : interval_counter_bank
`default_nettype wire

// File: tb/tb_interval_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_interval_counter_bank                                   |
// | Purpose : Directed self-checking bench for interval_counter_bank,    |
// |           built with 4-bit counters so free-run wrap is reachable.   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_interval_counter_bank;

   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 4;
   localparam int PRESC_W = 8;

   logic                      clk;
   logic                      resetn;
   logic [7:0]                state;
   logic [NUM_CH-1:0]         ch_en;
   logic [2*NUM_CH-1:0]       mode;
   logic [NUM_CH*PRESC_W-1:0] interval;
   logic [NUM_CH*CNT_W-1:0]   limit;
   logic [NUM_CH-1:0]         irq_clr;
   logic [NUM_CH*CNT_W-1:0]   counter;
   logic [NUM_CH-1:0]         tick;
   logic [NUM_CH-1:0]         done;
   logic [NUM_CH-1:0]         irq;

   int checks   = 0;
   int failures = 0;
   int tick_cnt;

   interval_counter_bank #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .PRESC_W (PRESC_W)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .state    (state),
      .ch_en    (ch_en),
      .mode     (mode),
      .interval (interval),
      .limit    (limit),
      .irq_clr  (irq_clr),
      .counter  (counter),
      .tick     (tick),
      .done     (done),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      resetn   = 1'b0;
      state    = 8'd0;
      ch_en    = '0;
      mode     = '0;
      interval = '0;
      limit    = '0;
      irq_clr  = '0;

      // Reset state
      step(2);
      chk("rst_counter", 32'(counter), 32'h0);
      chk("rst_flags", {20'h0, tick, done, irq}, 32'h0);
      resetn = 1'b1;
      step(1);

      // Free-run ch0, interval=3
      state = 8'd1; ch_en = 4'b0001; mode = 8'h00; interval[7:0] = 8'd3; limit[3:0] = 4'd2;
      step(3);
      chk("free_no_tick_yet", {28'h0, counter[3:0]}, 32'd0);
      step(1);
      chk("free_cnt1", {28'h0, counter[3:0]}, 32'd1);
      chk("free_tick1", {31'h0, tick[0]}, 32'd1);
      step(1);
      chk("free_tick_pulse", {31'h0, tick[0]}, 32'd0);
      step(3);
      chk("free_cnt2", {28'h0, counter[3:0]}, 32'd2);
      step(4);
      chk("free_cnt3", {28'h0, counter[3:0]}, 32'd3);
      step(48);
      chk("free_cnt15", {28'h0, counter[3:0]}, 32'd15);
      chk("free_no_irq", {31'h0, irq[0]}, 32'd0);
      step(4);
      chk("free_wrap_cnt", {28'h0, counter[3:0]}, 32'd0);
      chk("free_wrap_irq", {31'h0, irq[0]}, 32'd1);
      state = 8'd0;
      step(1);
      chk("state_reset_clr", {27'h0, irq[0], counter[3:0]}, 32'd0);

      // Auto-reload ch0, interval=0, limit=2
      state = 8'd1; mode = 8'h01; interval[7:0] = 8'd0; limit[3:0] = 4'd2;
      step(1);
      chk("reload_cnt1", {28'h0, counter[3:0]}, 32'd1);
      step(1);
      chk("reload_cnt2", {28'h0, counter[3:0]}, 32'd2);
      irq_clr = 4'b0001;
      step(1);
      chk("reload_cnt0", {28'h0, counter[3:0]}, 32'd0);
      chk("reload_set_wins", {31'h0, irq[0]}, 32'd1);
      step(1);
      chk("reload_clr", {31'h0, irq[0]}, 32'd0);
      chk("reload_cnt1b", {28'h0, counter[3:0]}, 32'd1);
      irq_clr = 4'b0000;
      step(2);
      chk("reload_irq_again", {27'h0, irq[0], counter[3:0]}, 32'h10);
      state = 8'd0;
      step(1);

      // One-shot ch0, interval=1, limit=3
      state = 8'd1; mode = 8'h02; interval[7:0] = 8'd1; limit[3:0] = 4'd3;
      step(5);
      chk("oneshot_cnt2", {27'h0, done[0], counter[3:0]}, 32'h02);
      step(1);
      chk("oneshot_done", {26'h0, done[0], irq[0], counter[3:0]}, 32'h33);
      chk("oneshot_tick", {31'h0, tick[0]}, 32'd1);
      mode = 8'h00;  // leaving one-shot must not unfreeze the channel
      tick_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         step(1);
         if (tick[0]) tick_cnt++;
      end
      chk("oneshot_frozen_ticks", 32'(tick_cnt), 32'd0);
      chk("oneshot_frozen_cnt", {27'h0, done[0], counter[3:0]}, 32'h13);
      state = 8'd0;
      step(1);
      chk("oneshot_reset", {26'h0, done[0], irq[0], counter[3:0]}, 32'h00);

      // HALT and ch_en: ch0 and ch1 free-run, interval=1, ch1 disabled
      mode = 8'h00; interval = '0; interval[7:0] = 8'd1; interval[15:8] = 8'd1;
      state = 8'd1; ch_en = 4'b0001;
      step(5);
      chk("halt_pre_cnt", {28'h0, counter[3:0]}, 32'd2);
      state = 8'd2;
      step(10);
      chk("halt_hold", {27'h0, tick[0], counter[3:0]}, 32'h02);
      state = 8'd1;
      step(1);
      chk("halt_resume", {27'h0, tick[0], counter[3:0]}, 32'h13);
      chk("ch1_disabled", {28'h0, counter[7:4]}, 32'd0);
      ch_en = 4'b0011;
      step(2);
      chk("ch1_enabled", {28'h0, counter[7:4]}, 32'd1);
      chk("ch0_indep", {28'h0, counter[3:0]}, 32'd4);
      state = 8'd0; ch_en = 4'b0001;
      step(1);

      // Interval lowered mid-count
      interval[7:0] = 8'd10; state = 8'd1;
      step(7);
      interval[7:0] = 8'd4;
      step(1);
      chk("lower_no_tick", {27'h0, tick[0], counter[3:0]}, 32'h00);
      step(4);
      chk("lower_wait", {27'h0, tick[0], counter[3:0]}, 32'h00);
      step(1);
      chk("lower_tick", {27'h0, tick[0], counter[3:0]}, 32'h11);

      // Illegal state code acts as RESET
      interval[7:0] = 8'd0;
      step(2);
      chk("pre_illegal_cnt", {28'h0, counter[3:0]}, 32'd3);
      state = 8'd7;
      step(1);
      chk("illegal_state_clr", {28'h0, counter[3:0]}, 32'd0);

      // One-shot with limit=0 finishes on the first advance
      state = 8'd1; mode = 8'h02; limit[3:0] = 4'd0; interval[7:0] = 8'd2;
      step(2);
      chk("lim0_wait", {31'h0, done[0]}, 32'd0);
      step(1);
      chk("lim0_done", {26'h0, done[0], irq[0], counter[3:0]}, 32'h30);
      state = 8'd7;
      step(1);
      chk("lim0_clr", {30'h0, done[0], irq[0]}, 32'd0);

      // Asynchronous reset between clock edges
      state = 8'd1; mode = 8'h00; interval[7:0] = 8'd0;
      step(3);
      chk("async_pre", {28'h0, counter[3:0]}, 32'd3);
      #2;
      resetn = 1'b0;
      #1;
      chk("async_clear", {16'h0, counter}, 32'h0);
      chk("async_flags", {20'h0, tick, done, irq}, 32'h0);
      @(posedge clk);
      #1;
      resetn = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_interval_counter_bank
`default_nettype wire
